wb_master_port: RTL and testbench
=================================

Name: wb_master_port

Overview:
- Wishbone classic master that converts a simple valid/ready core-side request/response interface into single Wishbone cycles on a `wb_bus_t` master modport.
- It is the initiator end of the bus that the peripheral slaves (timer, etc.) respond to. CPU, DMA and debug blocks use it to reach those peripherals.
- One outstanding transaction at a time, with a bus timeout so that a dead slave cannot hang the requester.

Parameters:
- TIMEOUT_CYCLES, 255: BUS-state cycles without ack/err before the cycle is aborted. 0 disables the timeout.
- CNT_W, 8: timeout counter width. Must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rstn_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high together with req_valid_i
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  write data
- req_be_i  in  4  byte enables (writes only)
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  32  read data (0 for writes and errors)
- rsp_err_o  out  1  slave error or timeout
- rsp_timeout_o  out  1  error caused by timeout
- wb_bus  wb_bus_t.master  interface: drives wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_ms; samples wb_ack, wb_err, wb_dat_sm

Behaviour:
- Interface decision: one clock `clk`; reset `rstn_i` is asynchronous and active-low.
- Reset values:
  - state = IDLE
  - wb_cyc = wb_stb = wb_we = 0; wb_adr = 0; wb_sel = 0; wb_dat_ms = 0
  - rsp_valid_o = 0; rsp_rdata_o = 0; rsp_err_o = 0; rsp_timeout_o = 0
  - timeout counter = 0
  - req_ready_o = 1 (combinational, equal to state == IDLE)
- FSM: IDLE -> BUS -> RESP -> IDLE.
- IDLE:
  - On req_valid_i & req_ready_o, register we, addr, wdata and sel, then go to BUS.
  - sel = req_be_i for writes; sel = 4'hF for reads, because slaves support only full 32-bit reads.
  - Counter is cleared.
- BUS:
  - wb_cyc = wb_stb = 1. wb_adr, wb_we, wb_sel and wb_dat_ms come from the registered request and are stable for the whole cycle.
  - The counter increments each cycle.
  - If wb_ack | wb_err is sampled high:
    - capture rsp_err_o = wb_err and rsp_timeout_o = 0;
    - capture rsp_rdata_o = wb_dat_sm for a read with no error, otherwise 0;
    - go to RESP.
  - ack and err together count as an error, since slaves raise both on out-of-range addresses.
  - Timeout: if TIMEOUT_CYCLES != 0, the counter == TIMEOUT_CYCLES-1, and there is no ack/err this cycle, go to RESP with rsp_err_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 0.
  - Ack in the same cycle as timeout expiry: the ack wins and it is not a timeout.
- RESP:
  - wb_cyc = wb_stb = 0 (dropped in the cycle after ack).
  - rsp_valid_o = 1, with payload held stable until rsp_ready_i.
  - On rsp_ready_i, rsp_valid_o = 0 next cycle and the state returns to IDLE.
- Latency with a combinational-ack slave:
  - accept at cycle N;
  - wb_cyc/wb_stb high in N+1, ack sampled in N+1;
  - rsp_valid_o in N+2.
- Throughput: with rsp_ready_i tied high, a new request is accepted every 3 cycles at most.
- wb_ack/wb_err outside BUS are ignored.
- A write with req_be_i = 0 is still issued with wb_sel = 0; the slave treats it as a no-op and acks.
- wb_adr is passed unmodified; alignment is the requester's responsibility.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously). The in-flight transaction is dropped and no response is produced.
- Request inputs are ignored outside IDLE.

Decomposition:
- Shared package `wb_master_pkg` holds:
  - state enum `wbm_state_e` {IDLE, BUS, RESP};
  - `WB_SEL_FULL` = 4'hF;
  - `WBM_DEFAULT_TIMEOUT` = 255.
- No sub-module: the FSM, request/response registers and timeout counter stay in one module.

Test Plan:
- Write 0xDEADBEEF to 0x4, be = 4'hF, slave acks in the first BUS cycle -> wb_cyc high for exactly 1 cycle with wb_sel = F and wb_dat_ms = DEADBEEF; rsp_valid_o 2 cycles after accept; err = 0; rdata = 0.
- Read 0x8, slave returns 0x12345678 after 3 wait cycles -> wb_cyc high for 4 cycles, wb_sel = F, wb_we = 0; rsp_rdata_o = 0x12345678; err = 0.
- Read 0x10, slave asserts ack and err together -> rsp_err_o = 1, rsp_timeout_o = 0, rsp_rdata_o = 0.
- TIMEOUT_CYCLES = 4, slave never acks -> wb_cyc high for exactly 4 cycles, then rsp_err_o = 1 and rsp_timeout_o = 1. Repeat with ack arriving in the 4th cycle -> normal response, timeout = 0.
- Hold rsp_ready_i low for 5 cycles after a read -> rsp_valid_o and payload stable, req_ready_o = 0, a second req_valid_i is not accepted until 1 cycle after the rsp handshake.
- Assert rstn_i low during BUS -> wb_cyc, wb_stb and rsp_valid_o go to 0 asynchronously. After release, req_ready_o = 1 and no stale response appears.

Source files
------------

// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared state type and constants for the Wishbone master port
package wb_master_pkg;
    typedef enum logic [1:0] {IDLE, BUS, RESP} wbm_state_e;
    localparam logic [3:0] WB_SEL_FULL = 4'hF;
    localparam int WBM_DEFAULT_TIMEOUT = 255;
endpackage

// File: rtl/wb_bus_t.sv
// wb_bus_t: Wishbone classic bus signals with master and slave views
interface wb_bus_t;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_ms;
    logic        wb_ack;
    logic        wb_err;
    logic [31:0] wb_dat_sm;
    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_ms,
        input  wb_ack, wb_err, wb_dat_sm
    );
    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_ms,
        output wb_ack, wb_err, wb_dat_sm
    );
endinterface

// File: rtl/wb_master_port.sv
// wb_master_port: valid/ready request/response to single Wishbone classic cycles with bus timeout
module wb_master_port
    import wb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = WBM_DEFAULT_TIMEOUT,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    wb_bus_t.master     wb_bus
);
    wbm_state_e       state;
    logic             we;
    logic [31:0]      adr;
    logic [31:0]      wdat;
    logic [3:0]       sel;
    logic [CNT_W-1:0] cnt;
    logic             hit;
    logic             expire;
    assign req_ready_o      = state == IDLE;
    assign rsp_valid_o      = state == RESP;
    assign wb_bus.wb_cyc    = state == BUS;
    assign wb_bus.wb_stb    = state == BUS;
    assign wb_bus.wb_we     = we;
    assign wb_bus.wb_adr    = adr;
    assign wb_bus.wb_sel    = sel;
    assign wb_bus.wb_dat_ms = wdat;
    assign hit    = wb_bus.wb_ack | wb_bus.wb_err;
    // a slave response in the expiry cycle takes priority over the timeout
    assign expire = TIMEOUT_CYCLES != 0 && cnt == CNT_W'(TIMEOUT_CYCLES - 1) && !hit;
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state         <= IDLE;
            we            <= 1'b0;
            adr           <= '0;
            wdat          <= '0;
            sel           <= '0;
            cnt           <= '0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req_valid_i) begin
                        we    <= req_we_i;
                        adr   <= req_addr_i;
                        wdat  <= req_wdata_i;
                        sel   <= req_we_i ? req_be_i : WB_SEL_FULL;
                        state <= BUS;
                    end
                end
                BUS: begin
                    cnt <= cnt + 1'b1;
                    if (hit) begin
                        rsp_err_o     <= wb_bus.wb_err;
                        rsp_timeout_o <= 1'b0;
                        rsp_rdata_o   <= (!we && !wb_bus.wb_err) ? wb_bus.wb_dat_sm : '0;
                        state         <= RESP;
                    end else if (expire) begin
                        rsp_err_o     <= 1'b1;
                        rsp_timeout_o <= 1'b1;
                        rsp_rdata_o   <= '0;
                        state         <= RESP;
                    end
                end
                RESP: if (rsp_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_master_port.sv
// tb_wb_master_port: directed and randomized checks of wb_master_port against a transaction-level model
module tb_wb_master_port;
    localparam int TO = 4;
    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_be_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    int checks = 0;
    int failures = 0;

    wb_bus_t bus();

    wb_master_port #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rstn_i(rstn_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o), .wb_bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one full transaction; the slave answers in BUS cycle wait_n (never if wait_n >= TO)
    // emode: 0 ack, 1 err, 2 ack+err; hold: cycles rsp_ready_i stays low
    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input int wait_n, input int emode, input logic [31:0] sd, input int hold);
        int cyc_n;
        logic e_to, e_err;
        logic [31:0] e_rd, e_sel;
        cyc_n = wait_n < TO ? wait_n + 1 : TO;
        e_to  = wait_n >= TO;
        e_err = e_to || emode != 0;
        e_rd  = (!we && !e_err) ? sd : 32'h0;
        e_sel = we ? {28'h0, be} : 32'hF;
        @(negedge clk);
        chk("req_ready_idle", req_ready_o, 1);
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_wdata_i = d; req_be_i = be;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        req_we_i = 1'($urandom); req_addr_i = $urandom; req_wdata_i = $urandom; req_be_i = 4'($urandom);
        for (int k = 0; k < cyc_n; k++) begin
            @(negedge clk);
            chk("bus_cyc", bus.wb_cyc, 1);
            chk("bus_stb", bus.wb_stb, 1);
            chk("bus_we", bus.wb_we, we);
            chk("bus_adr", bus.wb_adr, a);
            chk("bus_sel", bus.wb_sel, e_sel);
            chk("bus_dat_ms", bus.wb_dat_ms, d);
            chk("req_ready_bus", req_ready_o, 0);
            chk("rsp_valid_bus", rsp_valid_o, 0);
            if (k == wait_n) begin
                bus.wb_ack = emode != 1; bus.wb_err = emode != 0; bus.wb_dat_sm = sd;
            end else bus.wb_dat_sm = $urandom;
            @(posedge clk);
            #1 bus.wb_ack = 1'b0; bus.wb_err = 1'b0;
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            chk("rsp_valid", rsp_valid_o, 1);
            chk("rsp_cyc_low", bus.wb_cyc, 0);
            chk("rsp_stb_low", bus.wb_stb, 0);
            chk("rsp_rdata", rsp_rdata_o, e_rd);
            chk("rsp_err", rsp_err_o, e_err);
            chk("rsp_timeout", rsp_timeout_o, e_to);
            chk("req_ready_resp", req_ready_o, 0);
            if (h == hold) rsp_ready_i = 1'b1;
            else begin
                req_valid_i = 1'b1; bus.wb_ack = 1'($urandom); bus.wb_dat_sm = $urandom;
            end
            @(posedge clk);
            #1 rsp_ready_i = 1'b0; req_valid_i = 1'b0; bus.wb_ack = 1'b0;
        end
        @(negedge clk);
        chk("post_rsp_valid", rsp_valid_o, 0);
        chk("post_req_ready", req_ready_o, 1);
        chk("post_cyc", bus.wb_cyc, 0);
    endtask

    initial begin
        bus.wb_ack = 1'b0; bus.wb_err = 1'b0; bus.wb_dat_sm = '0;
        #2;
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_cyc", bus.wb_cyc, 0);
        chk("rst_stb", bus.wb_stb, 0);
        chk("rst_adr", bus.wb_adr, 0);
        chk("rst_sel", bus.wb_sel, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rdata", rsp_rdata_o, 0);
        repeat (2) @(negedge clk);
        rstn_i = 1'b1;
        // directed cases
        txn(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 32'hAAAA5555, 0);
        txn(1'b0, 32'h8, 32'h0, 4'h3, 3, 0, 32'h12345678, 0);
        txn(1'b0, 32'h10, 32'h0, 4'hF, 0, 2, 32'hCAFEF00D, 0);
        txn(1'b0, 32'h20, 32'h0, 4'hF, 99, 0, 32'h11111111, 0);
        txn(1'b1, 32'h24, 32'h5A5A5A5A, 4'h0, 1, 0, 32'h0, 0);
        txn(1'b0, 32'h30, 32'h0, 4'hF, 2, 1, 32'h77777777, 0);
        txn(1'b0, 32'h40, 32'h0, 4'hF, 1, 0, 32'h87654321, 5);
        // slave responses outside BUS are ignored
        @(negedge clk);
        bus.wb_ack = 1'b1; bus.wb_err = 1'b1;
        @(posedge clk);
        #1 bus.wb_ack = 1'b0; bus.wb_err = 1'b0;
        @(negedge clk);
        chk("idle_ack_cyc", bus.wb_cyc, 0);
        chk("idle_ack_rsp", rsp_valid_o, 0);
        chk("idle_ack_ready", req_ready_o, 1);
        // asynchronous reset during BUS drops the transaction
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h50; req_wdata_i = 32'hFFFF0000; req_be_i = 4'hF;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_cyc", bus.wb_cyc, 1);
        #2 rstn_i = 1'b0;
        #1;
        chk("async_rst_cyc", bus.wb_cyc, 0);
        chk("async_rst_stb", bus.wb_stb, 0);
        chk("async_rst_rsp", rsp_valid_o, 0);
        chk("async_rst_ready", req_ready_o, 1);
        chk("async_rst_adr", bus.wb_adr, 0);
        chk("async_rst_dat", bus.wb_dat_ms, 0);
        @(negedge clk);
        rstn_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_rsp", rsp_valid_o, 0);
            chk("post_rst_cyc", bus.wb_cyc, 0);
            chk("post_rst_ready", req_ready_o, 1);
        end
        // randomized transactions
        for (int i = 0; i < 40; i++)
            txn(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 2)) * int'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
